uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter (wr_uart/w_data/tx_full of uart_top) among N_REQ

---
 rtl/uart_arb_pkg.sv | 27 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types, constants and the round-robin search used by the UART TX arbiter.
package uart_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int BURST_W = 8;
    localparam int MAX_REQ = 8;

    // First set bit of valid at or after ptr, wrapping modulo n; returns ptr when none is set.
    function automatic int next_rr(input int ptr, input logic [MAX_REQ-1:0] valid, input int n);
        int pick;
        int idx;
        pick = ptr;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (valid[idx[2:0]]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin winner select: first valid requester at or after the pointer.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [MAX_REQ-1:0] valid_ext;

    always_comb begin
        valid_ext        = '0;
        valid_ext[N-1:0] = valid;
        idx              = IW'(next_rr(int'(ptr), valid_ext, N));
        any              = |valid;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the uart_top TX FIFO write port among N_REQ byte sources.
// Define UART_ARB_PRIO_EN to give requester 0 strict priority at every arbitration point.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 64,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               wr_uart,
    output logic [7:0]         w_data,
    input  logic               tx_full,
    output logic [IW-1:0]      grant_id,
    output logic               busy,
    output arb_state_t         dbg_state
);

    // Handshake: a byte moves when req_valid[i] & req_ready[i] at a rising edge; a requester
    // holds valid, data and last stable until that edge, and ready never depends on valid.

    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    arb_state_t         state_q, state_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [TW-1:0]      idle_q, idle_d;
    logic               wr_uart_q, wr_uart_d;
    logic [7:0]         w_data_q, w_data_d;

    logic [N_REQ-1:0]   pick_valid;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [IW-1:0]      win_idx;
    logic               lock_req;

    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;
    logic               can_send;
    logic               accept;
    logic               burst_done;
    logic               timed_out;
    logic               release_grant;
    logic [IW-1:0]      grant_next;

`ifdef UART_ARB_PRIO_EN
    // Requester 0 bypasses the rotation; the rest share the pointer among themselves.
    localparam logic [N_REQ-1:0] REQ0_MASK = N_REQ'(1);
    assign pick_valid = req_valid & ~REQ0_MASK;
    assign win_idx    = req_valid[0] ? '0 : pick_idx;
    assign lock_req   = req_valid[0] | pick_any;
`else
    assign pick_valid = req_valid;
    assign win_idx    = pick_idx;
    assign lock_req   = pick_any;
`endif

    rr_pick #(.N(N_REQ)) u_rr_pick (
        .valid (pick_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == IW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    // The gap cycle after each accept lets tx_full reflect that write before the next byte.
    always_comb begin
        can_send  = (state_q == LOCKED) && !tx_full && !wr_uart_q;
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = can_send && (grant_q == IW'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        burst_d   = burst_q;
        idle_d    = idle_q;
        wr_uart_d = 1'b0;
        w_data_d  = w_data_q;

        accept        = can_send && sel_valid;
        burst_done    = accept && ((burst_q + BURST_W'(1)) == BURST_W'(MAX_BURST));
        timed_out     = (state_q == LOCKED) && !sel_valid && (idle_q == TW'(IDLE_TIMEOUT - 1));
        release_grant = (accept && sel_last) || burst_done || timed_out;
        grant_next    = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);

        case (state_q)
            IDLE: begin
                if (lock_req) begin
                    state_d = LOCKED;
                    grant_d = win_idx;
                    burst_d = '0;
                    idle_d  = '0;
                end
            end
            LOCKED: begin
                if (accept) begin
                    wr_uart_d = 1'b1;
                    w_data_d  = sel_data;
                    burst_d   = burst_q + BURST_W'(1);
                end
                // A valid byte held back by tx_full or the write gap is not idleness.
                if (sel_valid) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
                if (release_grant) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            burst_q   <= '0;
            idle_q    <= '0;
            wr_uart_q <= 1'b0;
            w_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            burst_q   <= burst_d;
            idle_q    <= idle_d;
            wr_uart_q <= wr_uart_d;
            w_data_q  <= w_data_d;
        end
    end

    assign wr_uart   = wr_uart_q;
    assign w_data    = w_data_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q == LOCKED);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenarios for uart_tx_arbiter with per-requester byte queues and a write-port scoreboard.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N_REQ = 2;
    localparam int GW    = 1;
    localparam int W     = 11;

    logic               clk;
    logic               reset;
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               wr_uart;
    logic [7:0]         w_data;
    logic               tx_full;
    logic [GW-1:0]      grant_id;
    logic               busy;
    arb_state_t         dbg_state;

    logic [8:0]   src0_q[$];
    logic [8:0]   src1_q[$];
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;

    uart_tx_arbiter #(.N_REQ(2), .MAX_BURST(16), .IDLE_TIMEOUT(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .tx_full   (tx_full),
        .grant_id  (grant_id),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        if (src0_q.size() != 0) begin
            req_valid[0]   = 1'b1;
            req_last[0]    = src0_q[0][8];
            req_data[7:0]  = src0_q[0][7:0];
        end
        if (src1_q.size() != 0) begin
            req_valid[1]   = 1'b1;
            req_last[1]    = src1_q[0][8];
            req_data[15:8] = src1_q[0][7:0];
        end
    endtask

    task automatic send(input int src, input logic [7:0] data, input logic last);
        if (src == 0) src0_q.push_back({last, data});
        else          src1_q.push_back({last, data});
    endtask

    task automatic expect_byte(input logic [2:0] id, input logic [7:0] data);
        exp_q.push_back({id, data});
    endtask

    // One clock: judge handshakes, retire accepted bytes, present queue heads, score the write port.
    task automatic tick();
        logic         take0, take1;
        logic [W-1:0] got, want;
        #1;
        take0 = req_valid[0] & req_ready[0];
        take1 = req_valid[1] & req_ready[1];
        @(posedge clk);
        if (take0) src0_q.delete(0);
        if (take1) src1_q.delete(0);
        #1;
        drive();
        @(negedge clk);
        if (wr_uart) begin
            checks++;
            got = {3'(grant_id), w_data};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: write id=%0d data=%h with nothing expected", got[10:8], got[7:0]);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL scoreboard: got id=%0d data=%h, want id=%0d data=%h",
                             got[10:8], got[7:0], want[10:8], want[7:0]);
                end
            end
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src0_q.size() != 0 || src1_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || src0_q.size() != 0 || src1_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s_drain: %0d bytes still expected, busy=%b after %0d cycles, required 0 and idle",
                     name, exp_q.size(), busy, n);
            exp_q.delete();
            src0_q.delete();
            src1_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        tx_full = 1'b0;
        send(0, 8'hA0, 1'b1);
        send(1, 8'hB0, 1'b1);
        expect_byte(0, 8'hA0);
        expect_byte(1, 8'hB0);
        drive();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({req_ready, wr_uart, w_data, grant_id, busy} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: ready=%b wr=%b data=%h grant=%0d busy=%b, required all 0",
                         req_ready, wr_uart, w_data, grant_id, busy);
            end
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: state=%0d, required IDLE", dbg_state);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({busy, grant_id, wr_uart} !== {1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_first_grant: busy=%b grant=%0d wr=%b, required 1 0 0", busy, grant_id, wr_uart);
        end
        tick();
        checks++;
        if (wr_uart !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_write: wr=%b at cycle 2, required 1", wr_uart);
        end
        wait_drain(100, "reset");
    endtask

    task automatic test_packet();
        send(0, 8'h41, 1'b0);
        send(0, 8'h42, 1'b0);
        send(0, 8'h43, 1'b1);
        send(1, 8'h55, 1'b1);
        expect_byte(0, 8'h41);
        expect_byte(0, 8'h42);
        expect_byte(0, 8'h43);
        expect_byte(1, 8'h55);
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({busy, grant_id, req_ready[1]} !== {1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL packet_hold: busy=%b grant=%0d ready1=%b, required 1 0 0", busy, grant_id, req_ready[1]);
        end
        wait_drain(100, "packet");
    endtask

    task automatic test_max_burst();
        for (int k = 0; k < 20; k++) send(0, 8'(k), 1'b0);
        send(1, 8'h66, 1'b1);
        for (int k = 0; k < 16; k++) expect_byte(0, 8'(k));
`ifdef UART_ARB_PRIO_EN
        for (int k = 16; k < 20; k++) expect_byte(0, 8'(k));
        expect_byte(1, 8'h66);
`else
        expect_byte(1, 8'h66);
        for (int k = 16; k < 20; k++) expect_byte(0, 8'(k));
`endif
        wait_drain(400, "max_burst");
    endtask

    task automatic test_tx_full();
        for (int k = 0; k < 6; k++) begin
            send(0, 8'hC0 + 8'(k), k == 5);
            expect_byte(0, 8'hC0 + 8'(k));
        end
        for (int i = 0; i < 5; i++) tick();
        tx_full = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if ({req_ready, wr_uart} !== '0) begin
                errors++;
                $display("FAIL full_stall: ready=%b wr=%b while tx_full, required 0", req_ready, wr_uart);
            end
            checks++;
            if ({busy, grant_id} !== {1'b1, 1'b0}) begin
                errors++;
                $display("FAIL full_grant: busy=%b grant=%0d while tx_full, required 1 0", busy, grant_id);
            end
        end
        tx_full = 1'b0;
        wait_drain(100, "tx_full");
    endtask

    task automatic test_timeout();
        send(0, 8'hD0, 1'b0);
        send(0, 8'hD1, 1'b0);
        expect_byte(0, 8'hD0);
        expect_byte(0, 8'hD1);
        expect_byte(1, 8'h77);
        for (int t = 1; t <= 70; t++) begin
            tick();
            if (t == 10) send(1, 8'h77, 1'b1);
            if (t == 68) begin
                checks++;
                if ({busy, grant_id} !== {1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL timeout_early: busy=%b grant=%0d at cycle 68, required 1 0", busy, grant_id);
                end
            end
            if (t == 69) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_release: busy=%b at cycle 69, required 0", busy);
                end
            end
            if (t == 70) begin
                checks++;
                if ({busy, grant_id} !== {1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL timeout_next: busy=%b grant=%0d at cycle 70, required 1 1", busy, grant_id);
                end
            end
        end
        wait_drain(100, "timeout");
    endtask

    task automatic test_simultaneous();
        for (int r = 0; r < 3; r++) begin
            send(0, 8'h30 + 8'(r), 1'b1);
            expect_byte(0, 8'h30 + 8'(r));
            wait_drain(50, "simul_lone");
            send(0, 8'hE0 + 8'(r), 1'b1);
            send(1, 8'hF0 + 8'(r), 1'b1);
`ifdef UART_ARB_PRIO_EN
            expect_byte(0, 8'hE0 + 8'(r));
            expect_byte(1, 8'hF0 + 8'(r));
`else
            expect_byte(1, 8'hF0 + 8'(r));
            expect_byte(0, 8'hE0 + 8'(r));
`endif
            wait_drain(50, "simul_pair");
        end
    endtask

    task automatic test_reset_mid_packet();
        bit found;
        send(0, 8'h91, 1'b0);
        send(0, 8'h92, 1'b0);
        send(0, 8'h93, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (req_valid[0] && req_ready[0]) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_handshake: no req_ready for requester 0 within 10 cycles, required 1");
        end
        reset = 1'b0;
        exp_q.delete();
        src0_q.delete();
        src1_q.delete();
        drive();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({wr_uart, busy, grant_id, req_ready} !== '0) begin
                errors++;
                $display("FAIL midreset_clear: wr=%b busy=%b grant=%0d ready=%b, required all 0",
                         wr_uart, busy, grant_id, req_ready);
            end
        end
        reset = 1'b1;
        send(0, 8'h91, 1'b0);
        send(0, 8'h92, 1'b0);
        send(0, 8'h93, 1'b1);
        send(1, 8'hA5, 1'b1);
        expect_byte(0, 8'h91);
        expect_byte(0, 8'h92);
        expect_byte(0, 8'h93);
        expect_byte(1, 8'hA5);
        tick();
        tick();
        checks++;
        if ({busy, grant_id} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midreset_regrant: busy=%b grant=%0d, required 1 0", busy, grant_id);
        end
        wait_drain(100, "midreset");
    endtask

    initial begin
        reset     = 1'b0;
        tx_full   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        @(negedge clk);
        test_reset();
        test_packet();
        test_max_burst();
        test_tx_full();
        test_timeout();
        test_simultaneous();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
